// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and the
// issue/writeback sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;
    localparam logic [3:0] OP_NEG = 4'd11;

    // Positions inside the 5-bit flag vector {GE,POS,OVF,CARRY,ZERO}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_POS   = 3;
    localparam int FLAG_GE    = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC   = 3'd1,
        S_CAPT   = 3'd2,
        S_DSTART = 3'd3,
        S_DGUARD = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Issue/writeback stage around the ALU: accepts one op from decode, holds the
// ALU inputs stable, waits out the ALU latency and emits a one-cycle writeback.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int N           = 32,
    parameter int REG_W       = 4,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic             CLK,
    input  logic             rst,
    // Decode side: a request transfers on any rising edge where req_valid and
    // req_ready are both high; req_* must be stable while req_valid waits.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic             req_uns,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    input  logic [REG_W-1:0] req_rd,
    input  logic [REG_W-1:0] req_rh,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_uns,
    output logic             alu_start,
    input  logic [N-1:0]     alu_result,
    input  logic [N-1:0]     alu_high,
    input  logic [4:0]       alu_flags,
    input  logic             alu_finished,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic [REG_W-1:0] wb_rh,
    output logic [N-1:0]     wb_data,
    output logic [N-1:0]     wb_high,
    output logic             wb_high_en,
    output logic [4:0]       wb_flags,
    output logic             wb_err,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            high_en_q;
    logic            accept, is_div, div_zero, capture, timeout;

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    assign alu_start = (state == S_DSTART);
    assign state_dbg = state;
    assign accept    = req_valid & req_ready;
    assign is_div    = (req_op == OP_DIV);
    assign div_zero  = is_div && (req_b == '0);
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        timeout  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (div_zero)    state_nx = S_IDLE;
                    else if (is_div) state_nx = S_DSTART;
                    else             state_nx = S_EXEC;
                end
            end
            S_EXEC:   state_nx = S_CAPT;
            S_CAPT: begin
                capture  = 1'b1;
                state_nx = S_IDLE;
            end
            S_DSTART: state_nx = S_DGUARD;
            // alu_finished may still reflect the previous DIV here, so skip it
            S_DGUARD: state_nx = S_WAIT;
            S_WAIT: begin
                if (alu_finished) begin
                    capture  = 1'b1;
                    state_nx = S_IDLE;
                end else if (cnt_inc == CW'(DIV_TIMEOUT)) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            high_en_q  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_uns    <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_rh      <= '0;
            wb_data    <= '0;
            wb_high    <= '0;
            wb_high_en <= 1'b0;
            wb_flags   <= '0;
            wb_err     <= 1'b0;
        end else begin
            state    <= state_nx;
            wb_valid <= 1'b0;
            wb_err   <= 1'b0;
            if (state == S_WAIT) cnt <= cnt_inc;
            if (accept) begin
                alu_a      <= req_a;
                alu_b      <= req_b;
                alu_uns    <= req_uns;
                // A DIV by zero never reaches the ALU, so keep the opcode idle
                alu_opcode <= div_zero ? 4'd0 : req_op;
                wb_rd      <= req_rd;
                wb_rh      <= req_rh;
                high_en_q  <= (req_op == OP_MUL) || is_div;
                cnt        <= '0;
                if (div_zero) begin
                    wb_valid   <= 1'b1;
                    wb_err     <= 1'b1;
                    wb_data    <= '1;
                    wb_high    <= req_a;
                    wb_high_en <= 1'b1;
                    wb_flags   <= '0;
                end
            end
            if (capture) begin
                wb_valid   <= 1'b1;
                wb_data    <= alu_result;
                wb_high    <= alu_high;
                wb_high_en <= high_en_q;
                wb_flags   <= alu_flags;
                alu_opcode <= '0;
            end
            if (timeout) begin
                wb_valid   <= 1'b1;
                wb_err     <= 1'b1;
                wb_data    <= '0;
                wb_high    <= '0;
                wb_high_en <= 1'b0;
                wb_flags   <= '0;
                alu_opcode <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; the bench plays the ALU by driving
// hand-computed result/high/flags values.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int N     = 32;
    localparam int REG_W = 4;

    logic             CLK = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = '0;
    logic             req_uns = 1'b0;
    logic [N-1:0]     req_a = '0;
    logic [N-1:0]     req_b = '0;
    logic [REG_W-1:0] req_rd = '0;
    logic [REG_W-1:0] req_rh = '0;
    logic [N-1:0]     alu_a, alu_b;
    logic [3:0]       alu_opcode;
    logic             alu_uns, alu_start;
    logic [N-1:0]     alu_result = '0;
    logic [N-1:0]     alu_high = '0;
    logic [4:0]       alu_flags = '0;
    logic             alu_finished = 1'b0;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd, wb_rh;
    logic [N-1:0]     wb_data, wb_high;
    logic             wb_high_en;
    logic [4:0]       wb_flags;
    logic             wb_err, busy;
    logic [2:0]       state_dbg;

    int errors = 0;
    int checks = 0;

    alu_sequencer #(.N(N), .REG_W(REG_W), .DIV_TIMEOUT(40)) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_uns(req_uns), .req_a(req_a), .req_b(req_b),
        .req_rd(req_rd), .req_rh(req_rh),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_uns(alu_uns), .alu_start(alu_start),
        .alu_result(alu_result), .alu_high(alu_high), .alu_flags(alu_flags),
        .alu_finished(alu_finished),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rh(wb_rh),
        .wb_data(wb_data), .wb_high(wb_high), .wb_high_en(wb_high_en),
        .wb_flags(wb_flags), .wb_err(wb_err), .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [REG_W-1:0] rd,
                         input logic [REG_W-1:0] rh);
        req_op = op; req_a = a; req_b = b; req_rd = rd; req_rh = rh;
        req_uns = 1'b0; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready op=%0d got=%b want=1", op, req_ready);
        end
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    // Steps negedges until wb_valid is seen or the budget runs out.
    task automatic wait_wb(input int max, output int n);
        n = 0;
        while (wb_valid !== 1'b1 && n < max) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({wb_valid, wb_err, alu_start, alu_opcode, wb_data, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got wbv=%b err=%b st=%b op=%0d data=%h busy=%b want all 0",
                     wb_valid, wb_err, alu_start, alu_opcode, wb_data, busy);
        end
        checks++;
        if (req_ready !== 1'b1 || state_dbg !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL reset_idle got ready=%b state=%0d want 1/0", req_ready, state_dbg);
        end
        rst = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_add();
        int n;
        alu_result = 32'd12; alu_high = '0; alu_flags = 5'b11000;
        issue(OP_ADD, 32'd5, 32'd7, 4'd3, 4'd0);
        checks++;
        if (alu_opcode !== OP_ADD || alu_a !== 32'd5 || alu_b !== 32'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL add_alu_inputs got op=%0d a=%0d b=%0d busy=%b want 1/5/7/1",
                     alu_opcode, alu_a, alu_b, busy);
        end
        wait_wb(10, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL add_latency got=%0d want=2 negedges after accept", n);
        end
        checks++;
        if (wb_rd !== 4'd3 || wb_data !== 32'd12 || wb_flags[FLAG_ZERO] !== 1'b0 ||
            wb_high_en !== 1'b0 || wb_err !== 1'b0) begin
            errors++;
            $display("FAIL add_wb got rd=%0d data=%0d zero=%b hen=%b err=%b want 3/12/0/0/0",
                     wb_rd, wb_data, wb_flags[FLAG_ZERO], wb_high_en, wb_err);
        end
        checks++;
        if (alu_opcode !== 4'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_idle_after got op=%0d ready=%b want 0/1", alu_opcode, req_ready);
        end
        @(negedge CLK);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_wb_pulse got=%b want=0", wb_valid);
        end
    endtask

    task automatic test_sub_back_to_back();
        int n;
        alu_result = 32'd0; alu_flags = 5'b10001;
        issue(OP_SUB, 32'd4, 32'd4, 4'd5, 4'd0);
        wait_wb(10, n);
        checks++;
        if (n !== 2 || wb_data !== 32'd0 || wb_flags !== 5'b10001 || wb_rd !== 4'd5) begin
            errors++;
            $display("FAIL sub_wb got n=%0d data=%0d flags=%b rd=%0d want 2/0/10001/5",
                     n, wb_data, wb_flags, wb_rd);
        end
        // still in the writeback cycle: the next op goes in right now
        alu_result = 32'h30; alu_flags = 5'b11000;
        issue(OP_AND, 32'hF0, 32'h3C, 4'd6, 4'd0);
        checks++;
        if (wb_valid !== 1'b0 || alu_opcode !== OP_AND) begin
            errors++;
            $display("FAIL b2b_accept got wbv=%b op=%0d want 0/%0d", wb_valid, alu_opcode, OP_AND);
        end
        wait_wb(10, n);
        checks++;
        if (n !== 2 || wb_data !== 32'h30 || wb_rd !== 4'd6 || wb_flags[FLAG_ZERO] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wb got n=%0d data=%h rd=%0d zero=%b want 2/30/6/0",
                     n, wb_data, wb_rd, wb_flags[FLAG_ZERO]);
        end
        @(negedge CLK);
    endtask

    task automatic test_mul();
        int n;
        alu_result = 32'd0; alu_high = 32'd1; alu_flags = 5'b10001;
        issue(OP_MUL, 32'h10000, 32'h10000, 4'd1, 4'd2);
        wait_wb(10, n);
        checks++;
        if (n !== 2 || wb_data !== 32'd0 || wb_high !== 32'd1 || wb_high_en !== 1'b1 ||
            wb_rd !== 4'd1 || wb_rh !== 4'd2) begin
            errors++;
            $display("FAIL mul_wb got n=%0d data=%h high=%h hen=%b rd=%0d rh=%0d want 2/0/1/1/1/2",
                     n, wb_data, wb_high, wb_high_en, wb_rd, wb_rh);
        end
        @(negedge CLK);
    endtask

    task automatic test_div();
        int n;
        alu_result = 32'd14; alu_high = 32'd2; alu_flags = 5'b11000;
        issue(OP_DIV, 32'd100, 32'd7, 4'd4, 4'd8);
        checks++;
        if (alu_start !== 1'b1 || alu_opcode !== OP_DIV) begin
            errors++;
            $display("FAIL div_start got start=%b op=%0d want 1/%0d", alu_start, alu_opcode, OP_DIV);
        end
        @(negedge CLK);
        alu_finished = 1'b1;
        checks++;
        if (alu_start !== 1'b0 || state_dbg !== 3'(S_DGUARD)) begin
            errors++;
            $display("FAIL div_start_pulse got start=%b state=%0d want 0/%0d",
                     alu_start, state_dbg, S_DGUARD);
        end
        @(negedge CLK);
        alu_finished = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || state_dbg !== 3'(S_WAIT) || alu_start !== 1'b0) begin
            errors++;
            $display("FAIL div_stale_finished got wbv=%b state=%0d start=%b want 0/%0d/0",
                     wb_valid, state_dbg, alu_start, S_WAIT);
        end
        repeat (30) @(negedge CLK);
        alu_finished = 1'b1;
        @(negedge CLK);
        alu_finished = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'd14 || wb_high !== 32'd2 || wb_err !== 1'b0 ||
            wb_high_en !== 1'b1 || wb_rh !== 4'd8) begin
            errors++;
            $display("FAIL div_wb got wbv=%b data=%0d high=%0d err=%b hen=%b rh=%0d want 1/14/2/0/1/8",
                     wb_valid, wb_data, wb_high, wb_err, wb_high_en, wb_rh);
        end
        @(negedge CLK);
    endtask

    task automatic test_div_zero();
        issue(OP_DIV, 32'd123, 32'd0, 4'd7, 4'd9);
        checks++;
        if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_data !== 32'hFFFF_FFFF ||
            wb_high !== 32'd123 || wb_high_en !== 1'b1) begin
            errors++;
            $display("FAIL div0_wb got wbv=%b err=%b data=%h high=%0d hen=%b want 1/1/ffffffff/123/1",
                     wb_valid, wb_err, wb_data, wb_high, wb_high_en);
        end
        checks++;
        if (alu_start !== 1'b0 || alu_opcode !== 4'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL div0_no_start got start=%b op=%0d ready=%b want 0/0/1",
                     alu_start, alu_opcode, req_ready);
        end
        @(negedge CLK);
    endtask

    task automatic test_div_timeout();
        int n;
        alu_result = 32'd55; alu_high = 32'd66; alu_flags = 5'b11111;
        issue(OP_DIV, 32'd9, 32'd3, 4'd2, 4'd3);
        wait_wb(80, n);
        checks++;
        if (n !== 42) begin
            errors++;
            $display("FAIL div_timeout_latency got=%0d want=42 negedges after accept", n);
        end
        checks++;
        if (wb_err !== 1'b1 || wb_data !== 32'd0 || wb_high_en !== 1'b0) begin
            errors++;
            $display("FAIL div_timeout_wb got err=%b data=%0d hen=%b want 1/0/0",
                     wb_err, wb_data, wb_high_en);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        issue(OP_DIV, 32'd50, 32'd5, 4'd1, 4'd1);
        repeat (10) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        checks++;
        if (state_dbg !== 3'(S_IDLE) || req_ready !== 1'b1 || alu_opcode !== 4'd0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait got state=%0d ready=%b op=%0d wbv=%b want 0/1/0/0",
                     state_dbg, req_ready, alu_opcode, wb_valid);
        end
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (wb_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_no_wb got=%0d writebacks want=0", seen);
        end
    endtask

    task automatic test_unknown_op();
        int n;
        alu_result = 32'hABCD; alu_flags = 5'b00010;
        issue(4'd13, 32'd1, 32'd2, 4'd10, 4'd11);
        wait_wb(10, n);
        checks++;
        if (n !== 2 || wb_data !== 32'hABCD || wb_err !== 1'b0 || wb_high_en !== 1'b0 ||
            wb_rd !== 4'd10) begin
            errors++;
            $display("FAIL unknown_op_wb got n=%0d data=%h err=%b hen=%b rd=%0d want 2/abcd/0/0/10",
                     n, wb_data, wb_err, wb_high_en, wb_rd);
        end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_back_to_back();
        test_mul();
        test_div();
        test_div_zero();
        test_div_timeout();
        test_reset_mid_wait();
        test_unknown_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
